timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 35 +++
 rtl/timer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared definitions for the timer slave controller.
//   - register map of the timer slave (period bytes, snapshot bytes, control, snapshot strobe)
//   - command opcodes accepted on the cmd_* interface
//   - controller FSM state encoding
package timer_ctrl_pkg;

  localparam logic [3:0] ADDR_MAX0     = 4'd0;
  localparam logic [3:0] ADDR_MAX1     = 4'd1;
  localparam logic [3:0] ADDR_MAX2     = 4'd2;
  localparam logic [3:0] ADDR_MAX3     = 4'd3;
  localparam logic [3:0] ADDR_SNAP0    = 4'd4;
  localparam logic [3:0] ADDR_SNAP1    = 4'd5;
  localparam logic [3:0] ADDR_SNAP2    = 4'd6;
  localparam logic [3:0] ADDR_SNAP3    = 4'd7;
  localparam logic [3:0] ADDR_CTL      = 4'd8;
  localparam logic [3:0] ADDR_SNAPSHOT = 4'd9;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_STOP = 2'd1;
  localparam logic [1:0] OP_SNAP = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_MAX    = 3'd1,
    ST_WR_CTL    = 3'd2,
    ST_WR_SNAP   = 3'd3,
    ST_SNAP_WAIT = 3'd4,
    ST_RD_SNAP   = 3'd5
`ifdef TIMER_CTRL_IRQ_ACK_EN
    , ST_IRQ_ACK = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/timer_ctrl.sv
// timer_ctrl: command-driven master for an 8-bit timer slave bus.
//   Commands (cmd_valid/cmd_ready, cmd_op): LOAD writes the 32-bit period to
//   MAX0..3 then the control byte; STOP clears the control register; SNAP
//   strobes a snapshot, waits SNAP_WAIT ce cycles, reads SNAP0..3 and pulses
//   snap_valid with the assembled count on snap_data. Opcode 3 is swallowed.
// Ports:
//   clk, reset (async, active high), ce (clock enable for bus and FSM)
//   cmd_valid, cmd_ready, cmd_op, cmd_period, cmd_auto, cmd_irq_en
//   snap_valid, snap_data
//   t_cs, t_rw (1=read), t_a, t_wdata, t_rdata, t_irq : timer slave bus
//   tick (terminal-count pulse), busy (FSM not idle)
// Build option TIMER_CTRL_IRQ_ACK_EN: t_irq is serviced from IDLE by
//   rewriting the control byte (IRQ_ACK state); otherwise tick is simply the
//   rising edge of t_irq.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned SNAP_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_auto,
  input  logic        cmd_irq_en,
  output logic        snap_valid,
  output logic [31:0] snap_data,
  output logic        t_cs,
  output logic        t_rw,
  output logic [3:0]  t_a,
  output logic [7:0]  t_wdata,
  input  logic [7:0]  t_rdata,
  input  logic        t_irq,
  output logic        tick,
  output logic        busy
);

  localparam logic [7:0] WAIT_LAST = (SNAP_WAIT == 0) ? 8'd0 : 8'(SNAP_WAIT - 1);

  state_t      r_state;
  logic [1:0]  r_byte;
  logic [7:0]  r_wait;
  logic [31:0] r_period;
  logic [7:0]  r_ctl;
  logic [23:0] r_snap_acc;
  logic [31:0] r_snap_data;
  logic        r_snap_valid;
  logic        r_tick;
`ifndef TIMER_CTRL_IRQ_ACK_EN
  logic        r_irq_d;
`endif

  logic        w_accept;
  logic        w_cs;
  logic        w_rw;
  logic [3:0]  w_a;
  logic [7:0]  w_wdata;

`ifdef TIMER_CTRL_IRQ_ACK_EN
  // A pending interrupt wins over a command presented in the same cycle.
  assign cmd_ready = (r_state == ST_IDLE) && !t_irq;
`else
  assign cmd_ready = (r_state == ST_IDLE);
`endif
  assign w_accept   = cmd_valid && cmd_ready && ce;
  assign busy       = (r_state != ST_IDLE);
  assign snap_valid = r_snap_valid;
  assign snap_data  = r_snap_data;
  assign tick       = r_tick;

  // Bus fields decoded from state; strobes only appear on ce cycles and all
  // fields fall back to idle values whenever no strobe is issued.
  always_comb begin
    w_cs    = 1'b0;
    w_rw    = 1'b1;
    w_a     = '0;
    w_wdata = '0;
    case (r_state)
      ST_WR_MAX: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_a     = ADDR_MAX0 + {2'b00, r_byte};
        w_wdata = r_period[{r_byte, 3'b000} +: 8];
      end
      ST_WR_CTL: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_a     = ADDR_CTL;
        w_wdata = r_ctl;
      end
      ST_WR_SNAP: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_a     = ADDR_SNAPSHOT;
        w_wdata = 8'h01;
      end
      ST_RD_SNAP: begin
        w_cs = 1'b1;
        w_a  = ADDR_SNAP0 + {2'b00, r_byte};
      end
`ifdef TIMER_CTRL_IRQ_ACK_EN
      ST_IRQ_ACK: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_a     = ADDR_CTL;
        w_wdata = r_ctl[1] ? r_ctl : {r_ctl[7:1], 1'b0};
      end
`endif
      default: ;
    endcase
  end

  assign t_cs    = w_cs && ce;
  assign t_rw    = t_cs ? w_rw : 1'b1;
  assign t_a     = t_cs ? w_a : '0;
  assign t_wdata = t_cs ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_byte       <= '0;
      r_wait       <= '0;
      r_period     <= '0;
      r_ctl        <= '0;
      r_snap_acc   <= '0;
      r_snap_data  <= '0;
      r_snap_valid <= 1'b0;
      r_tick       <= 1'b0;
`ifndef TIMER_CTRL_IRQ_ACK_EN
      r_irq_d      <= 1'b0;
`endif
    end else begin
      r_snap_valid <= 1'b0;
`ifdef TIMER_CTRL_IRQ_ACK_EN
      r_tick       <= 1'b0;
`else
      r_irq_d      <= t_irq;
      r_tick       <= t_irq && !r_irq_d;
`endif
      if (ce) begin
        case (r_state)
          ST_IDLE: begin
`ifdef TIMER_CTRL_IRQ_ACK_EN
            if (t_irq) begin
              r_state <= ST_IRQ_ACK;
            end else
`endif
            if (w_accept) begin
              case (cmd_op)
                OP_LOAD: begin
                  r_period <= cmd_period;
                  r_ctl    <= {5'b0, cmd_irq_en, cmd_auto, 1'b1};
                  r_state  <= ST_WR_MAX;
                end
                // STOP reuses WR_CTL with the latched control copy cleared.
                OP_STOP: begin
                  r_ctl   <= '0;
                  r_state <= ST_WR_CTL;
                end
                OP_SNAP: r_state <= ST_WR_SNAP;
                default: ;
              endcase
            end
          end
          ST_WR_MAX: begin
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) r_state <= ST_WR_CTL;
          end
          ST_WR_CTL: r_state <= ST_IDLE;
          ST_WR_SNAP: begin
            r_wait  <= '0;
            r_state <= (SNAP_WAIT == 0) ? ST_RD_SNAP : ST_SNAP_WAIT;
          end
          ST_SNAP_WAIT: begin
            if (r_wait == WAIT_LAST) r_state <= ST_RD_SNAP;
            else                     r_wait  <= r_wait + 8'd1;
          end
          ST_RD_SNAP: begin
            r_byte <= r_byte + 2'd1;
            case (r_byte)
              2'd0: r_snap_acc[7:0]   <= t_rdata;
              2'd1: r_snap_acc[15:8]  <= t_rdata;
              2'd2: r_snap_acc[23:16] <= t_rdata;
              default: begin
                r_snap_data  <= {t_rdata, r_snap_acc};
                r_snap_valid <= 1'b1;
                r_state      <= ST_IDLE;
              end
            endcase
          end
`ifdef TIMER_CTRL_IRQ_ACK_EN
          ST_IRQ_ACK: begin
            if (!r_ctl[1]) r_ctl[0] <= 1'b0;
            r_tick  <= 1'b1;
            r_state <= ST_IDLE;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: table of commands with the expected bus strobe
// sequence, busy length, snap_valid count and snap_data, plus hand-written
// sequences for reset during a snapshot read and for t_irq handling.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_period = '0;
  logic        cmd_auto = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_data;
  logic        t_cs, t_rw;
  logic [3:0]  t_a;
  logic [7:0]  t_wdata;
  logic [7:0]  t_rdata;
  logic        t_irq = 1'b0;
  logic        tick, busy;

  timer_ctrl #(.SNAP_WAIT(2)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_auto(cmd_auto), .cmd_irq_en(cmd_irq_en),
    .snap_valid(snap_valid), .snap_data(snap_data),
    .t_cs(t_cs), .t_rw(t_rw), .t_a(t_a), .t_wdata(t_wdata),
    .t_rdata(t_rdata), .t_irq(t_irq), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timer slave model: count is held by the bench, copied on a SNAPSHOT write.
  logic [31:0] tmr_count = '0;
  logic [31:0] snap_reg = '0;
  always @(posedge clk) if (t_cs && !t_rw && t_a == 4'd9) snap_reg <= tmr_count;
  always_comb begin
    t_rdata = '0;
    case (t_a)
      4'd4: t_rdata = snap_reg[7:0];
      4'd5: t_rdata = snap_reg[15:8];
      4'd6: t_rdata = snap_reg[23:16];
      4'd7: t_rdata = snap_reg[31:24];
      default: ;
    endcase
  end

  // Bus monitor: log entry = {rw, addr, write data (00 for reads)}.
  logic [12:0] log_q[$];
  int ce_viol = 0, nvalid_cnt = 0, tick_cnt = 0;
  always @(negedge clk) begin
    if (t_cs) begin
      log_q.push_back({t_rw, t_a, t_rw ? 8'h00 : t_wdata});
      if (!ce) ce_viol++;
    end
    if (snap_valid) nvalid_cnt++;
    if (tick) tick_cnt++;
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      period;
    logic             au;
    logic             ie;
    logic             tog;
    logic [31:0]      count;
    int               n;
    logic [4:0][12:0] exp;
    int               bsy;
    int               nval;
    logic [31:0]      snap;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] per, input logic au,
                              input logic ie, input logic tog, input logic [31:0] cnt, input int n,
                              input logic [12:0] e0, input logic [12:0] e1, input logic [12:0] e2,
                              input logic [12:0] e3, input logic [12:0] e4,
                              input int bsy, input int nval, input logic [31:0] snap);
    vec_t v;
    v.op = op; v.period = per; v.au = au; v.ie = ie; v.tog = tog; v.count = cnt; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    v.bsy = bsy; v.nval = nval; v.snap = snap;
    return v;
  endfunction

  task automatic do_cmd(input vec_t v, input int idx);
    int base, v0, c0, bc;
    bit done;
    logic [12:0] act, exp;
    tmr_count = v.count;
    @(negedge clk);
    base = log_q.size(); v0 = nvalid_cnt; c0 = ce_viol;
    ce = 1'b1; cmd_op = v.op; cmd_period = v.period; cmd_auto = v.au; cmd_irq_en = v.ie;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ce = v.tog ? 1'b0 : 1'b1;
    bc = 0; done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
      bc++;
      @(posedge clk); #1;
      if (v.tog) ce = ~ce;
    end
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
    ce = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_nstrobe", idx), 32'(log_q.size() - base), 32'(v.n));
    for (int i = 0; i < v.n; i++) begin
      if (base + i < log_q.size()) begin
        act = log_q[base + i];
        exp = v.exp[i];
        // snapshot strobe data is don't-care
        if (exp[11:8] == 4'd9) begin act[7:0] = '0; exp[7:0] = '0; end
        chk($sformatf("v%0d_strobe%0d", idx, i), 32'(act), 32'(exp));
      end
    end
    if (v.bsy >= 0) chk($sformatf("v%0d_busy_cycles", idx), 32'(bc), 32'(v.bsy));
    chk($sformatf("v%0d_snap_valid", idx), 32'(nvalid_cnt - v0), 32'(v.nval));
    chk($sformatf("v%0d_snap_data", idx), snap_data, v.snap);
    chk($sformatf("v%0d_ce_gate", idx), 32'(ce_viol - c0), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int base, t0, v0;
  bit acc, ack, found;

  initial begin
    vecs[0] = mk(2'd0, 32'h0000_0005, 1, 1, 0, 32'h0, 5,
                 13'h0005, 13'h0100, 13'h0200, 13'h0300, 13'h0807, 5, 0, 32'h0);
    vecs[1] = mk(2'd2, 32'h0, 0, 0, 0, 32'h1234_5678, 5,
                 13'h0900, 13'h1400, 13'h1500, 13'h1600, 13'h1700, 7, 1, 32'h1234_5678);
    vecs[2] = mk(2'd0, 32'hA1B2_C3D4, 0, 0, 1, 32'h0, 5,
                 13'h00D4, 13'h01C3, 13'h02B2, 13'h03A1, 13'h0801, -1, 0, 32'h1234_5678);
    vecs[3] = mk(2'd1, 32'h0, 0, 0, 0, 32'h0, 1,
                 13'h0800, 13'h0, 13'h0, 13'h0, 13'h0, 1, 0, 32'h1234_5678);
    vecs[4] = mk(2'd3, 32'hFFFF_FFFF, 1, 1, 0, 32'h0, 0,
                 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 0, 0, 32'h1234_5678);
    vecs[5] = mk(2'd2, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 5,
                 13'h0900, 13'h1400, 13'h1500, 13'h1600, 13'h1700, -1, 1, 32'hDEAD_BEEF);
    vecs[6] = mk(2'd0, 32'h0102_0304, 0, 1, 0, 32'h0, 5,
                 13'h0004, 13'h0103, 13'h0202, 13'h0301, 13'h0805, 5, 0, 32'hDEAD_BEEF);
    vecs[7] = mk(2'd2, 32'h0, 0, 0, 0, 32'h0BAD_F00D, 5,
                 13'h0900, 13'h1400, 13'h1500, 13'h1600, 13'h1700, 7, 1, 32'h0BAD_F00D);

    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus", 32'({t_cs, t_rw, t_a, t_wdata}), 32'({1'b0, 1'b1, 4'h0, 8'h00}));
    chk("rst_snap", 32'({snap_valid, tick}), 32'd0);
    chk("rst_snap_data", snap_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) do_cmd(vecs[i], i);

    // Reset while reading snapshot byte 2
    tmr_count = 32'hCAFE_F00D;
    v0 = nvalid_cnt;
    @(negedge clk);
    ce = 1'b1; cmd_op = 2'd2; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (t_cs && t_rw && t_a == 4'd6) begin found = 1'b1; break; end
    end
    chk("mid_rst_reached_byte2", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_bus", 32'({t_cs, t_rw, t_a, t_wdata}), 32'({1'b0, 1'b1, 4'h0, 8'h00}));
    chk("mid_rst_pulses", 32'({snap_valid, tick}), 32'd0);
    chk("mid_rst_snap_data", snap_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_no_snap_valid", 32'(nvalid_cnt - v0), 32'd0);
    do_cmd(vecs[7], 7);

`ifdef TIMER_CTRL_IRQ_ACK_EN
    // Control byte is {irq_en, auto, enable}: auto=1 rewrites 07, auto=0/irq_en=1 rewrites 04.
    v = vecs[0]; v.snap = 32'h0BAD_F00D;
    do_cmd(v, 10);
    base = log_q.size(); t0 = tick_cnt;
    @(negedge clk);
    ce = 1'b1; cmd_op = 2'd0; cmd_period = 32'h9; cmd_auto = 1'b1; cmd_irq_en = 1'b1;
    cmd_valid = 1'b1; t_irq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      ack = t_cs && !t_rw && (t_a == 4'h8) && t_irq;
      @(posedge clk); #1;
      if (acc) cmd_valid = 1'b0;
      if (ack) t_irq = 1'b0;
    end
    chk("irq_nstrobe", 32'(log_q.size() - base), 32'd6);
    chk("irq_ack_first", 32'(log_q[base]), 32'h0807);
    chk("irq_load_after", 32'(log_q[base + 1]), 32'h0009);
    chk("irq_load_ctl", 32'(log_q[base + 5]), 32'h0807);
    chk("irq_tick", 32'(tick_cnt - t0), 32'd1);
    v = vecs[6]; v.snap = 32'h0BAD_F00D;
    do_cmd(v, 11);
    base = log_q.size(); t0 = tick_cnt;
    @(negedge clk);
    t_irq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ack = t_cs && !t_rw && (t_a == 4'h8) && t_irq;
      @(posedge clk); #1;
      if (ack) t_irq = 1'b0;
    end
    chk("irq_noauto_nstrobe", 32'(log_q.size() - base), 32'd1);
    chk("irq_noauto_ctl", 32'(log_q[base]), 32'h0804);
    chk("irq_noauto_tick", 32'(tick_cnt - t0), 32'd1);
`else
    // tick on rising edge of t_irq only; t_irq does not block commands
    t0 = tick_cnt;
    @(posedge clk); #1 t_irq = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_ready_while_high", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("tick_single_pulse", 32'(tick_cnt - t0), 32'd1);
    @(posedge clk); #1 t_irq = 1'b0;
    repeat (3) @(negedge clk);
    chk("tick_no_fall_pulse", 32'(tick_cnt - t0), 32'd1);
    @(posedge clk); #1 t_irq = 1'b1;
    repeat (4) @(negedge clk);
    chk("tick_second_edge", 32'(tick_cnt - t0), 32'd2);
    @(posedge clk); #1 t_irq = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
